// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction memory write port bundle
interface imem_loader_if #(
  parameter int N  = 32,
  parameter int AW = 7
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;

  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
  modport slave  (input in_valid, in_data, output in_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader; IMEM_LOADER_CLEAR_EN zero-fills unloaded words
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         cpu_reset,
  output logic         done
);
  localparam int B     = N / 8;
  localparam int BW    = (B > 1) ? $clog2(B) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef IMEM_LOADER_CLEAR_EN
    S_CLEAR,
`endif
    S_DONE
  } state_t;

  state_t        state, next;
  logic          ready;
  logic          accept;
  logic          word_end;
  logic          load_end;
  int            hdr_len;
  logic [CW-1:0] len_clamped;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] word_idx;
  logic [BW-1:0] byte_idx;
  logic [N-1:0]  shbuf;
  logic [N-1:0]  assembled;
  logic          we_r;
  logic [AW-1:0] waddr_r;
  logic [N-1:0]  wdata_r;

  // Bytes enter at the top and drift down, so the first byte ends in bits 7:0.
  assign assembled = (shbuf >> 8) | (N'(bus.in_data) << (N - 8));
  assign accept    = ready && bus.in_valid;
  assign word_end  = accept && (byte_idx == BW'(B - 1));
  assign load_end  = word_end && ((word_idx + CW'(1)) == word_cnt);

  always_comb begin
    hdr_len = (bus.in_data == 8'd0) ? 256 : int'(bus.in_data);
    if (hdr_len > DEPTH) hdr_len = DEPTH;
    len_clamped = CW'(hdr_len);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next  = state;
    ready = 1'b0;
    case (state)
      S_IDLE: if (start) next = S_LEN;
      S_LEN: begin
        ready = 1'b1;
        if (bus.in_valid) next = S_DATA;
      end
      S_DATA: begin
        ready = 1'b1;
        if (load_end) begin
`ifdef IMEM_LOADER_CLEAR_EN
          next = (word_cnt != CW'(DEPTH)) ? S_CLEAR : S_DONE;
`else
          next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CLEAR_EN
      S_CLEAR: if (word_idx == CW'(DEPTH - 1)) next = S_DONE;
`endif
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      we_r     <= 1'b0;
      waddr_r  <= '0;
      wdata_r  <= '0;
      word_cnt <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      shbuf    <= '0;
    end else begin
      we_r <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          done <= 1'b0;
        end
        S_LEN: if (accept) begin
          word_cnt <= len_clamped;
          word_idx <= '0;
          byte_idx <= '0;
        end
        S_DATA: if (accept) begin
          shbuf <= assembled;
          if (word_end) begin
            byte_idx <= '0;
            we_r     <= 1'b1;
            waddr_r  <= word_idx[AW-1:0];
            wdata_r  <= assembled;
            word_idx <= word_idx + CW'(1);
          end else begin
            byte_idx <= byte_idx + BW'(1);
          end
        end
`ifdef IMEM_LOADER_CLEAR_EN
        S_CLEAR: begin
          we_r     <= 1'b1;
          waddr_r  <= word_idx[AW-1:0];
          wdata_r  <= '0;
          word_idx <= word_idx + CW'(1);
        end
`endif
        S_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign bus.we       = we_r;
  assign bus.waddr    = waddr_r;
  assign bus.wdata    = wdata_r;
  assign cpu_reset    = busy;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int N = 32, AW = 7, B = N / 8, DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset, start, busy, cpu_reset, done;

  imem_loader_if #(.N(N), .AW(AW)) bus ();

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .cpu_reset(cpu_reset), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] got_addr[$];
  logic [N-1:0]  got_data[$];
  longint        got_time[$];
  bit            we_busy_ok;
  logic [7:0]    fixed_q[$];

  always @(negedge clk) begin
    if (bus.we) begin
      got_addr.push_back(bus.waddr);
      got_data.push_back(bus.wdata);
      got_time.push_back($time);
      if (!busy) we_busy_ok = 1'b0;
    end
  end

  // mode: 0 = valid held high, 1 = valid toggles 1,0,1,0, 2 = random stalls
  task automatic run_load(input int hdr, input int mode, input bit mid_start, input bit probe);
    logic [7:0]    q[$];
    logic [AW-1:0] exp_addr[$];
    logic [N-1:0]  exp_data[$];
    longint        final_t[$];
    logic [N-1:0]  word;
    int lc, n, guard;
    bit v, rdy, tog;
    longint t, done_t;

    if (fixed_q.size() > 0) begin
      q = fixed_q;
      fixed_q.delete();
      hdr = int'(q[0]);
    end else begin
      q.push_back(8'(hdr));
    end
    lc = (hdr == 0) ? 256 : hdr;
    if (lc > DEPTH) lc = DEPTH;
    while (q.size() < 1 + B * lc) q.push_back(8'($urandom));

    for (int w = 0; w < lc; w++) begin
      word = '0;
      for (int k = 0; k < B; k++) word = word + (N'(q[1 + w * B + k]) << (8 * k));
      exp_addr.push_back(AW'(w));
      exp_data.push_back(word);
    end
`ifdef IMEM_LOADER_CLEAR_EN
    for (int a = lc; a < DEPTH; a++) begin
      exp_addr.push_back(AW'(a));
      exp_data.push_back('0);
    end
`endif

    got_addr.delete(); got_data.delete(); got_time.delete();
    we_busy_ok = 1'b1;
    start = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_cpu_reset", cpu_reset, 1);
    check("start_in_ready", bus.in_ready, 1);
    check("start_done_clear", done, 0);

    n = 0; tog = 1'b1; guard = 0;
    while (q.size() > 0 && guard < 20000) begin
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = q[0];
      start = mid_start && (n == 3);
      rdy = bus.in_ready;
      t = $time;
      @(negedge clk);
      if (v && rdy) begin
        if (n >= 1 && (n % B) == 0) final_t.push_back(t);
        void'(q.pop_front());
        n++;
      end
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    check("bytes_consumed", q.size(), 0);

    guard = 0;
    while (!done && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    done_t = $time;
    check("done_reached", done, 1);
    check("done_busy_low", busy, 0);
    check("done_cpu_reset_low", cpu_reset, 0);
    check("done_in_ready_low", bus.in_ready, 0);

    if (got_time.size() > 0) check("done_after_last_we", done_t - got_time[got_time.size() - 1], 10);
    check("we_while_busy", we_busy_ok, 1);

    if (probe) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
    end

    check("write_count", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("waddr[%0d]", i), got_addr[i], exp_addr[i]);
      check($sformatf("wdata[%0d]", i), got_data[i], exp_data[i]);
      if (i < lc && i < final_t.size())
        check($sformatf("we_latency[%0d]", i), got_time[i] - final_t[i], 10);
      else if (i >= lc)
        check($sformatf("clear_spacing[%0d]", i), got_time[i] - got_time[i - 1], 10);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_we", bus.we, 0);
    check("rst_waddr", bus.waddr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_reset", cpu_reset, 0);
    check("rst_done", done, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = (i == 0) ? 8'd5 : 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_we", bus.we, 0);
    repeat (6) @(negedge clk);
    check("midrst_no_write", got_addr.size(), 0);

    fixed_q = '{8'h02, 8'h24, 8'h00, 8'h02, 8'h8b, 8'h85, 8'h00, 8'h03, 8'h8b};
    run_load(0, 0, 1'b0, 1'b1);
    if (got_data.size() >= 2) begin
      check("basic_word0", got_data[0], 32'h8b020024);
      check("basic_word1", got_data[1], 32'h8b030085);
    end else begin
      check("basic_two_writes", got_data.size(), 2);
    end

    run_load(1, 1, 1'b1, 1'b0);
    run_load(0, 0, 1'b0, 1'b1);
    run_load(200, 2, 1'b0, 1'b0);
    run_load(9, 2, 1'b0, 1'b0);

    run_load(3, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b0, 1'b0);
    if (got_addr.size() > 0) check("restart_addr0", got_addr[0], 0);

    for (int r = 0; r < 4; r++) run_load($urandom_range(1, 255), 2, 1'($urandom_range(0, 1)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
